// File: rtl/count_seq_checker_if.sv
// Sample stream and status bundle between a free-running counter and its sequence checker.
interface count_seq_checker_if #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4
);
    logic [CNT_W-1:0]  cnt_in;
    logic              cnt_vld;
    logic              clr;
    logic              wrap_pulse;
    logic              err_pulse;
    logic              restart_pulse;
    logic              stalled;
    logic [WRAP_W-1:0] wrap_cnt;
    logic [ERR_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  last_val;

    // Source side: supplies samples and clear, observes checker status.
    modport master (
        output cnt_in, cnt_vld, clr,
        input  wrap_pulse, err_pulse, restart_pulse, stalled, wrap_cnt, err_cnt, last_val
    );

    // Checker side.
    modport slave (
        input  cnt_in, cnt_vld, clr,
        output wrap_pulse, err_pulse, restart_pulse, stalled, wrap_cnt, err_cnt, last_val
    );
endinterface

// File: rtl/count_seq_checker.sv
// Monitors a modulo-2^CNT_W counter stream: flags wraps, restarts, illegal jumps and stalls.
module count_seq_checker #(
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned WRAP_W    = 8,
    parameter int unsigned ERR_W     = 4,
    parameter int unsigned STALL_MAX = 4
) (
    input logic                  clk,
    input logic                  rst,
    count_seq_checker_if.slave   bus
);
    localparam int unsigned RUN_W = $clog2(STALL_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    typedef enum logic [1:0] {IDLE, TRACK, STALL} state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  last_q, last_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              wrap_p_q, wrap_p_d;
    logic              err_p_q, err_p_d;
    logic              rst_p_q, rst_p_d;
    logic [RUN_W-1:0]  run_inc;

    assign run_inc = run_q + RUN_W'(1);

    // Classify each accepted sample against the previous one and derive next state/statistics.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        last_d   = last_q;
        wrap_d   = wrap_q;
        err_d    = err_q;
        wrap_p_d = 1'b0;
        err_p_d  = 1'b0;
        rst_p_d  = 1'b0;
        if (bus.cnt_vld) begin
            if (state_q == IDLE) begin
                last_d  = bus.cnt_in;
                run_d   = '0;
                state_d = TRACK;
            end else if (bus.cnt_in == last_q) begin
                // run saturates once STALL is reached so long stalls cannot wrap it
                if (state_q != STALL) begin
                    run_d = run_inc;
                    if (run_inc == RUN_W'(STALL_MAX)) begin
                        state_d = STALL;
                    end
                end
            end else begin
                last_d  = bus.cnt_in;
                run_d   = '0;
                state_d = TRACK;
                if (last_q != MAX_VAL && bus.cnt_in == last_q + CNT_W'(1)) begin
                    // legal step, nothing to report
                end else if (last_q == MAX_VAL && bus.cnt_in == '0) begin
                    wrap_p_d = 1'b1;
                    wrap_d   = wrap_q + WRAP_W'(1);
                end else if (bus.cnt_in == '0) begin
                    rst_p_d = 1'b1;
                end else begin
                    err_p_d = 1'b1;
                    if (err_q != '1) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
            end
        end
    end

    // State and statistics registers; rst and clr both return everything to IDLE/zero.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            state_q  <= IDLE;
            run_q    <= '0;
            last_q   <= '0;
            wrap_q   <= '0;
            err_q    <= '0;
            wrap_p_q <= 1'b0;
            err_p_q  <= 1'b0;
            rst_p_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            last_q   <= last_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            wrap_p_q <= wrap_p_d;
            err_p_q  <= err_p_d;
            rst_p_q  <= rst_p_d;
        end
    end

    assign bus.wrap_pulse    = wrap_p_q;
    assign bus.err_pulse     = err_p_q;
    assign bus.restart_pulse = rst_p_q;
    assign bus.stalled       = (state_q == STALL);
    assign bus.wrap_cnt      = wrap_q;
    assign bus.err_cnt       = err_q;
    assign bus.last_val      = last_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed scenarios plus randomized sample streams.
module tb_count_seq_checker;
    localparam int CNT_W = 3, WRAP_W = 8, ERR_W = 4, STALL_MAX = 4;
    localparam int MAXV = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              w;
        logic              e;
        logic              r;
        logic              s;
        logic [WRAP_W-1:0] wc;
        logic [ERR_W-1:0]  ec;
        logic [CNT_W-1:0]  lv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model state: plain integers describing what has been observed so far.
    bit have_ref;
    int ref_val, reps, wraps, errs;
    bit stalled_m;

    count_seq_checker_if #(.CNT_W(CNT_W), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

    count_seq_checker #(.CNT_W(CNT_W), .WRAP_W(WRAP_W), .ERR_W(ERR_W), .STALL_MAX(STALL_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, then advance the model and queue the expected outputs.
    task automatic step(input bit r, input bit c, input bit v, input int val);
        exp_t e;
        rst = r;
        bus.clr = c;
        bus.cnt_vld = v;
        bus.cnt_in = CNT_W'(val);
        @(posedge clk);
        e = '0;
        if (r || c) begin
            have_ref = 0; ref_val = 0; reps = 0; wraps = 0; errs = 0; stalled_m = 0;
        end else if (v) begin
            if (!have_ref) begin
                have_ref = 1;
                ref_val = val;
                reps = 0;
            end else if (val == ref_val) begin
                reps++;
                if (reps >= STALL_MAX) stalled_m = 1;
            end else begin
                reps = 0;
                stalled_m = 0;
                if (ref_val == MAXV && val == 0) begin
                    e.w = 1; wraps++;
                end else if (val == ref_val + 1) begin
                    // legal increment
                end else if (val == 0) begin
                    e.r = 1;
                end else begin
                    e.e = 1;
                    if (errs < (1 << ERR_W) - 1) errs++;
                end
                ref_val = val;
            end
        end
        e.s  = stalled_m;
        e.wc = WRAP_W'(wraps % (1 << WRAP_W));
        e.ec = ERR_W'(errs);
        e.lv = CNT_W'(ref_val);
        sb.push_back(e);
        #1;
    endtask

    task automatic seq(input int vals[$]);
        foreach (vals[i]) step(0, 0, 1, vals[i]);
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e, a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {bus.wrap_pulse, bus.err_pulse, bus.restart_pulse, bus.stalled,
                 bus.wrap_cnt, bus.err_cnt, bus.last_val};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got w=%b e=%b r=%b s=%b wc=%0d ec=%0d lv=%0d exp w=%b e=%b r=%b s=%b wc=%0d ec=%0d lv=%0d",
                         $time, a.w, a.e, a.r, a.s, a.wc, a.ec, a.lv, e.w, e.e, e.r, e.s, e.wc, e.ec, e.lv);
            end
        end
    end

    initial begin
        int cur;
        bus.clr = 0; bus.cnt_vld = 0; bus.cnt_in = '0;

        // reset then count through a wrap
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        seq('{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});
        step(0, 0, 0, 0);

        // illegal jump then resync
        step(1, 0, 0, 0);
        seq('{2, 3, 6, 7});

        // restart is not an error
        step(1, 0, 0, 0);
        seq('{4, 5, 0, 1});

        // stall entry and exit, plus a longer stall and a clr mid-stall
        step(1, 0, 0, 0);
        seq('{3, 3, 3, 3, 3, 4});
        seq('{4, 4, 4, 4, 4, 4, 4, 4, 4, 4});
        step(0, 1, 0, 0);
        seq('{4, 5});

        // error saturation then wrap counter modulo
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        repeat (10) seq('{5, 1});
        seq('{2, 3, 4, 5, 6, 7});
        repeat (257) seq('{0, 1, 2, 3, 4, 5, 6, 7});

        // clear priority with err_cnt at 3
        step(1, 0, 0, 0);
        seq('{0, 1, 5, 1, 4});
        step(0, 1, 1, 5);
        seq('{6, 7});
        step(1, 1, 1, 2);
        seq('{3, 4});

        // randomized streams
        cur = 0;
        repeat (800) begin
            int ch, nv;
            ch = $urandom_range(0, 99);
            if (ch < 60)      nv = (cur + 1) % (MAXV + 1);
            else if (ch < 78) nv = cur;
            else if (ch < 86) nv = 0;
            else              nv = $urandom_range(0, MAXV);
            step(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80), nv);
            cur = nv;
        end

        step(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Downstream monitor for the 3-bit `bits_counter`. It samples the counter value and checks every step against the expected +1 modulo 2^CNT_W sequence. It reports wrap-arounds, illegal jumps, counter restarts and stalls as registered pulses and flags, with saturating or modular statistics counters. It sits between the counter and the display/LED logic, and serves as an in-system self-check.

## Interface
- `CNT_W`, 3: width of the monitored count.
- `WRAP_W`, 8: width of the wrap counter.
- `ERR_W`, 4: width of the error counter.
- `STALL_MAX`, 4: consecutive unchanged samples that declare a stall (≥2).
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high. Highest priority.
- `cnt_in`  in  CNT_W  counter value (`{out2,out1,out0}` from the counter).
- `cnt_vld`  in  1  sample strobe; `cnt_in` is considered only when high.
- `clr`  in  1  synchronous clear of state and statistics; priority below `rst`.
- `wrap_pulse`  out  1  one-cycle pulse: legal step from max to 0.
- `err_pulse`  out  1  one-cycle pulse: illegal jump.
- `restart_pulse`  out  1  one-cycle pulse: jump to 0 from a non-max, nonzero value.
- `stalled`  out  1  level; high while in STALL.
- `wrap_cnt`  out  WRAP_W  number of wraps, modulo 2^WRAP_W.
- `err_cnt`  out  ERR_W  number of illegal jumps, saturating at all-ones.
- `last_val`  out  CNT_W  last accepted sample.

## Operation
- FSM states: IDLE (no reference sample), TRACK, STALL.
- Internal `run` counter: consecutive repeated samples, width clog2(STALL_MAX+1).
- **Reset / clr:**
  - State goes to IDLE.
  - All outputs go to 0: pulses, `stalled`, `wrap_cnt`, `err_cnt`, `last_val`.
  - `run` goes to 0.
  - If `clr` coincides with `cnt_vld`, the sample is discarded.
- **IDLE, `cnt_vld`:** `last_val<=cnt_in`, go to TRACK. No pulses or counts.
- **TRACK/STALL, `cnt_vld`:** classify `cnt_in` against `last_val` (M = 2^CNT_W−1):
  - **equal:** `run<=run+1`. When `run+1==STALL_MAX`, go to STALL. No pulses.
  - **last_val+1, last_val≠M:** legal step. `run<=0`, state to TRACK.
  - **last_val==M and cnt_in==0:** wrap. `wrap_pulse`, `wrap_cnt<=wrap_cnt+1` (wraps modulo 2^WRAP_W), `run<=0`, state to TRACK.
  - **cnt_in==0, last_val∉{0,M}:** restart (upstream reset). `restart_pulse` only. No error. `run<=0`, state to TRACK.
  - **anything else:** illegal jump. `err_pulse`, `err_cnt<=err_cnt+1` unless already all-ones, `run<=0`, state to TRACK.
  - In every non-equal case, `last_val<=cnt_in`. The next step is checked against the new value (resync, no repeated errors).
- **`cnt_vld` low:** state, `run` and `last_val` hold; pulses return to 0.
- Exactly one of `wrap_pulse`/`err_pulse`/`restart_pulse` fires per sample, at most.
- Leaving STALL happens on any non-equal sample, classified as above. `stalled` drops in the same registered update.

## Timing
- All outputs are registered. A sample accepted at edge N produces its pulse, counters, `last_val` and `stalled` after edge N; they are visible during cycle N+1.
- Pulses last exactly one cycle, even with back-to-back `cnt_vld`.
- `stalled` rises after the edge that accepts the STALL_MAX-th consecutive repeated sample (the STALL_MAX+1-th identical value overall, counting the reference).
- Throughput is one sample per clock. No backpressure.
- `rst` or `clr` mid-stall: `stalled` is 0 after that edge, and the next valid sample is a reference only.

## Test plan
- **Reset then count:** `rst` for 2 cycles, then `cnt_vld`=1 with 0,1,…,7,0,1.
  - All outputs 0 after reset.
  - One `wrap_pulse` the cycle after the 7→0 sample.
  - `wrap_cnt`=1, `err_pulse` never asserted.
- **Illegal jump:** samples 2,3,6,7.
  - `err_pulse` once, after the 6 sample; `err_cnt`=1.
  - 6→7 is accepted as legal (resync).
- **Restart vs error:** samples 4,5,0,1.
  - `restart_pulse` after the 0 sample.
  - `err_cnt` stays 0, `wrap_cnt` stays 0.
- **Stall:** samples 3,3,3,3,3,4 with STALL_MAX=4.
  - `stalled`=1 after the fifth 3.
  - `stalled`=0 after the 4, with no pulse.
- **Saturation / modulo:** inject 20 illegal jumps, then 257 wraps.
  - `err_cnt` holds at 15.
  - `wrap_cnt`=1 (257 mod 256).
- **Clear priority:** `clr` and `cnt_vld` together mid-count, with `err_cnt`=3.
  - All statistics are 0 and the sample is ignored.
  - The next sample only sets `last_val`; no pulse.
  - `rst` asserted with `clr` yields the same reset values.
